// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master: host / memory side, slave: the loader itself.
interface imem_loader_if;
  logic        InValid;
  logic [7:0]  InData;
  logic        InReady;
  logic [31:0] IAddr;
  logic [31:0] IDataIn;
  logic        RW;

  modport master (
    output InValid,
    output InData,
    input  InReady,
    input  IAddr,
    input  IDataIn,
    input  RW
  );

  modport slave (
    input  InValid,
    input  InData,
    output InReady,
    output IAddr,
    output IDataIn,
    output RW
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: takes a length-prefixed little-endian byte stream
// and writes it as 32-bit words at consecutive addresses, stalling the CPU
// while the load is in progress.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, all control outputs low, waiting for Start
// LEN0  | accepting low byte of the word count
// LEN1  | accepting high byte of the word count, length check
// BYTE  | assembling the current word, one byte per transfer
// WRITE | one-cycle write strobe for the assembled word
// DONE  | last load completed, waiting for Start
// ERR   | last load rejected (count too large), waiting for Start
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 175
) (
  input  logic CLK,
  input  logic RST,
  input  logic Start,
  imem_loader_if.slave bus,
  output logic CpuHold,
  output logic Busy,
  output logic Done,
  output logic Error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN0  = 3'd1;
  localparam logic [2:0] S_LEN1  = 3'd2;
  localparam logic [2:0] S_BYTE  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  logic [2:0]  state;
  logic [7:0]  len_lo;
  logic [15:0] word_cnt;
  logic [15:0] idx;
  logic [1:0]  byte_cnt;
  // Only the three lower bytes are stored; the fourth goes straight into the
  // write data register as it arrives.
  logic [23:0] asm_word;
  logic [31:0] iaddr;
  logic [31:0] idata;

  logic        in_ready;
  logic        xfer;
  logic [15:0] len_full;

  // Byte acceptance is purely a function of state so the host sees a stable
  // ready for the whole cycle.
  always_comb begin
    in_ready = (state == S_LEN0) || (state == S_LEN1) || (state == S_BYTE);
    xfer     = in_ready && bus.InValid;
    len_full = {bus.InData, len_lo};
  end

  // Sequencer: length capture, word assembly, write strobe and completion.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      len_lo   <= 8'h00;
      word_cnt <= 16'h0000;
      idx      <= 16'h0000;
      byte_cnt <= 2'd0;
      asm_word <= 24'h000000;
      iaddr    <= 32'h0000_0000;
      idata    <= 32'h0000_0000;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (Start) state <= S_LEN0;
        end
        S_LEN0: begin
          if (xfer) begin
            len_lo <= bus.InData;
            state  <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (xfer) begin
            word_cnt <= len_full;
            if (len_full == 16'h0000) begin
              state <= S_DONE;
            end else if (len_full > MAX_LEN) begin
              state <= S_ERR;
            end else begin
              idx      <= 16'h0000;
              byte_cnt <= 2'd0;
              state    <= S_BYTE;
            end
          end
        end
        S_BYTE: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: asm_word[7:0]   <= bus.InData;
              2'd1: asm_word[15:8]  <= bus.InData;
              2'd2: asm_word[23:16] <= bus.InData;
              default: begin
                // Address and data are latched here so they are valid for
                // the whole WRITE cycle and then simply hold.
                iaddr <= BASE_ADDR + {14'b0, idx, 2'b00};
                idata <= {bus.InData, asm_word};
                state <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          idx <= idx + 16'd1;
          if ((idx + 16'd1) == word_cnt) state <= S_DONE;
          else                           state <= S_BYTE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Control and status outputs decode directly from state.
  always_comb begin
    bus.InReady = in_ready;
    bus.RW      = (state == S_WRITE);
    bus.IAddr   = iaddr;
    bus.IDataIn = idata;
    Busy        = in_ready || (state == S_WRITE);
    CpuHold     = in_ready || (state == S_WRITE);
    Done        = (state == S_DONE);
    Error       = (state == S_ERR);
  end

endmodule
